uart_rx_control_path: RTL and testbench

Control FSM for the UART receiver, the receive-side counterpart of the transmit control path. It detects the start bit on an oversampled serial line and generates mid-bit sample strobes with bit indices. It walks through the data, parity-or-CRC and stop fields, and reports frame completion or errors. It drives the RX datapath, which shifts `rx_i` on each `sample_o` and checks parity/CRC.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_control_path.sv | 145 ++++++++++++++
 tb/tb_uart_rx_control_path.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and frame field widths
// used by both the RX and TX control paths.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE       = 3'd0,
    RX_START_BIT  = 3'd1,
    RX_DATA_BITS  = 3'd2,
    RX_PARITY_BIT = 3'd3,
    RX_CRC        = 3'd4,
    RX_STOP_BIT   = 3'd5
  } t_rx_states;

  localparam int DATA_BITS   = 8;
  localparam int CRC_BITS    = 8;
  localparam int PARITY_BITS = 1;
  localparam int STOP_BITS   = 1;

endpackage

// File: rtl/uart_rx_control_path.sv
// UART receive control FSM: start-bit qualification, mid-bit sample strobes
// with per-field bit indices, and frame done / framing / false-start pulses.
module uart_rx_control_path
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       rx_i,
  input  logic       crc_en_i,
  output logic       sample_o,
  output logic [4:0] bit_cnt_o,
  output logic       is_rx_idle_o,
  output logic       is_rx_start_o,
  output logic       is_rx_data_o,
  output logic       is_rx_parity_o,
  output logic       is_rx_crc_o,
  output logic       is_rx_stop_o,
  output logic       frame_done_o,
  output logic       framing_err_o,
  output logic       start_err_o
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);

  t_rx_states    state, state_d;
  logic [SW-1:0] s_cnt, s_cnt_d;
  logic [4:0]    b_cnt, b_cnt_d;
  logic          rx_q;
  logic          crc_mode, crc_mode_d;
  logic          field_last;
  t_rx_states    field_next;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= RX_IDLE;
      s_cnt    <= '0;
      b_cnt    <= '0;
      rx_q     <= 1'b1;
      crc_mode <= 1'b0;
    end else if (tick_i) begin
      state    <= state_d;
      s_cnt    <= s_cnt_d;
      b_cnt    <= b_cnt_d;
      rx_q     <= rx_i;
      crc_mode <= crc_mode_d;
    end
  end

  // Where the current field ends and which state follows it.
  always_comb begin
    field_last = 1'b0;
    field_next = RX_IDLE;
    case (state)
      RX_DATA_BITS: begin
        field_last = (b_cnt == 5'(DATA_BITS - 1));
        field_next = crc_mode ? RX_CRC : RX_PARITY_BIT;
      end
      RX_PARITY_BIT: begin
        field_last = (b_cnt == 5'(PARITY_BITS - 1));
        field_next = RX_STOP_BIT;
      end
      RX_CRC: begin
        field_last = (b_cnt == 5'(CRC_BITS - 1));
        field_next = RX_STOP_BIT;
      end
      RX_STOP_BIT: begin
        field_last = (b_cnt == 5'(STOP_BITS - 1));
        field_next = RX_IDLE;
      end
      default: begin
        field_last = 1'b0;
        field_next = RX_IDLE;
      end
    endcase
  end

  always_comb begin
    state_d       = state;
    s_cnt_d       = s_cnt;
    b_cnt_d       = b_cnt;
    crc_mode_d    = crc_mode;
    sample_o      = 1'b0;
    frame_done_o  = 1'b0;
    framing_err_o = 1'b0;
    start_err_o   = 1'b0;
    if (tick_i) begin
      case (state)
        RX_IDLE: begin
          // Only a high-to-low transition starts a frame, never a stuck-low line.
          if (rx_q && !rx_i) begin
            state_d    = RX_START_BIT;
            s_cnt_d    = '0;
            b_cnt_d    = '0;
            crc_mode_d = crc_en_i;
          end
        end
        RX_START_BIT: begin
          if (s_cnt == HALF_LAST) begin
            if (!rx_i) begin
              state_d = RX_DATA_BITS;
              s_cnt_d = '0;
            end else begin
              start_err_o = 1'b1;
              state_d     = RX_IDLE;
            end
          end else begin
            s_cnt_d = s_cnt + SW'(1);
          end
        end
        RX_DATA_BITS, RX_PARITY_BIT, RX_CRC, RX_STOP_BIT: begin
          if (s_cnt == BIT_LAST) begin
            sample_o = 1'b1;
            s_cnt_d  = '0;
            b_cnt_d  = b_cnt + 5'd1;
            if (field_last) begin
              b_cnt_d = '0;
              state_d = field_next;
              if (state == RX_STOP_BIT) begin
                frame_done_o  = rx_i;
                framing_err_o = !rx_i;
              end
            end
          end else begin
            s_cnt_d = s_cnt + SW'(1);
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  assign bit_cnt_o      = sample_o ? b_cnt : 5'd0;
  assign is_rx_idle_o   = (state == RX_IDLE);
  assign is_rx_start_o  = (state == RX_START_BIT);
  assign is_rx_data_o   = (state == RX_DATA_BITS);
  assign is_rx_parity_o = (state == RX_PARITY_BIT);
  assign is_rx_crc_o    = (state == RX_CRC);
  assign is_rx_stop_o   = (state == RX_STOP_BIT);

endmodule

// File: tb/tb_uart_rx_control_path.sv
// Scoreboard bench for uart_rx_control_path: frames are generated on a tick grid,
// expected strobes/pulses (kind, bit index, field, tick number) are queued up front.
module tb_uart_rx_control_path;

  localparam int OS = 16;

  localparam logic [1:0] K_SAMPLE = 2'd0;
  localparam logic [1:0] K_DONE   = 2'd1;
  localparam logic [1:0] K_FERR   = 2'd2;
  localparam logic [1:0] K_SERR   = 2'd3;

  localparam logic [2:0] F_IDLE   = 3'd1;
  localparam logic [2:0] F_START  = 3'd2;
  localparam logic [2:0] F_DATA   = 3'd3;
  localparam logic [2:0] F_PARITY = 3'd4;
  localparam logic [2:0] F_CRC    = 3'd5;
  localparam logic [2:0] F_STOP   = 3'd6;

  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  bit_idx;
    logic [2:0]  field;
    logic [31:0] tick;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       tick_i;
  logic       rx_i;
  logic       crc_en_i;
  logic       sample_o;
  logic [4:0] bit_cnt_o;
  logic       is_rx_idle_o, is_rx_start_o, is_rx_data_o;
  logic       is_rx_parity_o, is_rx_crc_o, is_rx_stop_o;
  logic       frame_done_o, framing_err_o, start_err_o;

  int          tick_gap   = 1;
  logic [31:0] tick_count = 32'd0;
  int          checks     = 0;
  int          passes     = 0;
  ev_t         exp_q[$];
  ev_t         obs_q[$];

  uart_rx_control_path #(.OVERSAMPLE(OS)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .tick_i        (tick_i),
    .rx_i          (rx_i),
    .crc_en_i      (crc_en_i),
    .sample_o      (sample_o),
    .bit_cnt_o     (bit_cnt_o),
    .is_rx_idle_o  (is_rx_idle_o),
    .is_rx_start_o (is_rx_start_o),
    .is_rx_data_o  (is_rx_data_o),
    .is_rx_parity_o(is_rx_parity_o),
    .is_rx_crc_o   (is_rx_crc_o),
    .is_rx_stop_o  (is_rx_stop_o),
    .frame_done_o  (frame_done_o),
    .framing_err_o (framing_err_o),
    .start_err_o   (start_err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] field_code();
    case ({is_rx_idle_o, is_rx_start_o, is_rx_data_o, is_rx_parity_o, is_rx_crc_o, is_rx_stop_o})
      6'b100000: return F_IDLE;
      6'b010000: return F_START;
      6'b001000: return F_DATA;
      6'b000100: return F_PARITY;
      6'b000010: return F_CRC;
      6'b000001: return F_STOP;
      default:   return 3'd0;
    endcase
  endfunction

  // Record every strobe/pulse mid-cycle, tagged with the tick it happened on.
  always @(negedge clk) begin
    if (sample_o)      obs_q.push_back('{K_SAMPLE, bit_cnt_o, field_code(), tick_count});
    if (frame_done_o)  obs_q.push_back('{K_DONE, 5'd0, field_code(), tick_count});
    if (framing_err_o) obs_q.push_back('{K_FERR, 5'd0, field_code(), tick_count});
    if (start_err_o)   obs_q.push_back('{K_SERR, 5'd0, field_code(), tick_count});
    if (tick_i) tick_count = tick_count + 32'd1;
  end

  task automatic tick_once(input logic b);
    rx_i   = b;
    tick_i = 1'b0;
    repeat (tick_gap - 1) @(posedge clk) #1;
    tick_i = 1'b1;
    @(posedge clk);
    #1;
    tick_i = 1'b0;
  endtask

  // Drives one frame and queues what the receiver should report for it.
  task automatic send_frame(input logic [7:0] data, input logic crc_en, input logic [7:0] crc,
                            input logic stop_bit, input int abort_at, input int hold_low,
                            input int toggle_at);
    logic [17:0] bits;
    int          nbits;
    int          base;
    int          limit;
    int          off;
    logic [2:0]  fld;
    logic [4:0]  idx;
    bits    = '1;
    bits[0] = 1'b0;
    bits[8:1] = data;
    if (crc_en) begin
      bits[16:9] = crc;
      bits[17]   = stop_bit;
      nbits      = 18;
    end else begin
      bits[9]  = ^data;
      bits[10] = stop_bit;
      nbits    = 11;
    end
    crc_en_i = crc_en;
    repeat (4) tick_once(1'b1);
    base  = int'(tick_count);
    limit = (abort_at >= 0) ? abort_at : 32'h4000_0000;
    for (int s = 0; s < nbits - 1; s++) begin
      off = OS / 2 + OS * (s + 1);
      if (s < 8) begin
        fld = F_DATA;   idx = 5'(s);
      end else if (s == nbits - 2) begin
        fld = F_STOP;   idx = 5'd0;
      end else if (crc_en) begin
        fld = F_CRC;    idx = 5'(s - 8);
      end else begin
        fld = F_PARITY; idx = 5'd0;
      end
      if (off < limit) begin
        exp_q.push_back('{K_SAMPLE, idx, fld, 32'(base + off)});
        if (fld == F_STOP)
          exp_q.push_back('{stop_bit ? K_DONE : K_FERR, 5'd0, F_STOP, 32'(base + off)});
      end
    end
    for (int t = 0; t < nbits * OS; t++) begin
      if (t == abort_at) return;
      if (t == toggle_at) crc_en_i = ~crc_en_i;
      tick_once(bits[t / OS]);
    end
    repeat (hold_low) tick_once(1'b0);
  endtask

  task automatic test_reset();
    logic [15:0] got;
    rst_ni = 1'b0; tick_i = 1'b1; rx_i = 1'b0; crc_en_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = {is_rx_idle_o, is_rx_start_o, is_rx_data_o, is_rx_parity_o, is_rx_crc_o, is_rx_stop_o,
           sample_o, frame_done_o, framing_err_o, start_err_o, 1'b0, bit_cnt_o};
    checks++;
    if (got !== 16'h8000)
      $display("[TB] FAIL reset_outputs: actual=%h required=%h", got, 16'h8000);
    else passes++;
    tick_i = 1'b0; rx_i = 1'b1; crc_en_i = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_parity_frame();
    ev_t e, o;
    send_frame(8'hA5, 1'b0, 8'h00, 1'b1, -1, 0, -1);
    repeat (4) tick_once(1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0)
        $display("[TB] FAIL parity_frame: actual=none required=k%0d b%0d f%0d t%0d", e.kind, e.bit_idx, e.field, e.tick);
      else begin
        o = obs_q.pop_front();
        if (o !== e)
          $display("[TB] FAIL parity_frame: actual=k%0d b%0d f%0d t%0d required=k%0d b%0d f%0d t%0d",
                   o.kind, o.bit_idx, o.field, o.tick, e.kind, e.bit_idx, e.field, e.tick);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0) $display("[TB] FAIL parity_extra: actual=%0d required=0", obs_q.size());
    else passes++;
    obs_q.delete();
  endtask

  task automatic test_crc_frame();
    ev_t e, o;
    send_frame(8'h3C, 1'b1, 8'h5A, 1'b1, -1, 0, -1);
    repeat (4) tick_once(1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0)
        $display("[TB] FAIL crc_frame: actual=none required=k%0d b%0d f%0d t%0d", e.kind, e.bit_idx, e.field, e.tick);
      else begin
        o = obs_q.pop_front();
        if (o !== e)
          $display("[TB] FAIL crc_frame: actual=k%0d b%0d f%0d t%0d required=k%0d b%0d f%0d t%0d",
                   o.kind, o.bit_idx, o.field, o.tick, e.kind, e.bit_idx, e.field, e.tick);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0) $display("[TB] FAIL crc_extra: actual=%0d required=0", obs_q.size());
    else passes++;
    obs_q.delete();
  endtask

  task automatic test_false_start();
    ev_t e, o;
    int  base;
    repeat (4) tick_once(1'b1);
    base = int'(tick_count);
    exp_q.push_back('{K_SERR, 5'd0, F_START, 32'(base + OS / 2)});
    repeat (4) tick_once(1'b0);
    repeat (20) tick_once(1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0)
        $display("[TB] FAIL false_start: actual=none required=k%0d b%0d f%0d t%0d", e.kind, e.bit_idx, e.field, e.tick);
      else begin
        o = obs_q.pop_front();
        if (o !== e)
          $display("[TB] FAIL false_start: actual=k%0d b%0d f%0d t%0d required=k%0d b%0d f%0d t%0d",
                   o.kind, o.bit_idx, o.field, o.tick, e.kind, e.bit_idx, e.field, e.tick);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0) $display("[TB] FAIL false_start_extra: actual=%0d required=0", obs_q.size());
    else passes++;
    checks++;
    if (is_rx_idle_o !== 1'b1) $display("[TB] FAIL false_start_idle: actual=%b required=1", is_rx_idle_o);
    else passes++;
    obs_q.delete();
  endtask

  task automatic test_framing_error();
    ev_t e, o;
    send_frame(8'h81, 1'b0, 8'h00, 1'b0, -1, 50, -1);
    checks++;
    if (is_rx_idle_o !== 1'b1) $display("[TB] FAIL framing_low_idle: actual=%b required=1", is_rx_idle_o);
    else passes++;
    send_frame(8'h0F, 1'b0, 8'h00, 1'b1, -1, 0, -1);
    repeat (4) tick_once(1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0)
        $display("[TB] FAIL framing_err: actual=none required=k%0d b%0d f%0d t%0d", e.kind, e.bit_idx, e.field, e.tick);
      else begin
        o = obs_q.pop_front();
        if (o !== e)
          $display("[TB] FAIL framing_err: actual=k%0d b%0d f%0d t%0d required=k%0d b%0d f%0d t%0d",
                   o.kind, o.bit_idx, o.field, o.tick, e.kind, e.bit_idx, e.field, e.tick);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0) $display("[TB] FAIL framing_extra: actual=%0d required=0", obs_q.size());
    else passes++;
    obs_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    ev_t e, o;
    send_frame(8'hC3, 1'b0, 8'h00, 1'b1, OS / 2 + OS * 4 - 2, 0, -1);
    rx_i = 1'b1; tick_i = 1'b0; rst_ni = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (is_rx_idle_o !== 1'b1) $display("[TB] FAIL mid_reset_idle: actual=%b required=1", is_rx_idle_o);
    else passes++;
    rst_ni = 1'b1;
    send_frame(8'h5A, 1'b0, 8'h00, 1'b1, -1, 0, -1);
    repeat (4) tick_once(1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0)
        $display("[TB] FAIL mid_reset: actual=none required=k%0d b%0d f%0d t%0d", e.kind, e.bit_idx, e.field, e.tick);
      else begin
        o = obs_q.pop_front();
        if (o !== e)
          $display("[TB] FAIL mid_reset: actual=k%0d b%0d f%0d t%0d required=k%0d b%0d f%0d t%0d",
                   o.kind, o.bit_idx, o.field, o.tick, e.kind, e.bit_idx, e.field, e.tick);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0) $display("[TB] FAIL mid_reset_extra: actual=%0d required=0", obs_q.size());
    else passes++;
    obs_q.delete();
  endtask

  task automatic test_slow_tick();
    ev_t e, o;
    tick_gap = 3;
    send_frame(8'h69, 1'b1, 8'hE7, 1'b1, -1, 0, 40);
    send_frame(8'h96, 1'b0, 8'h00, 1'b1, -1, 0, 40);
    repeat (4) tick_once(1'b1);
    tick_gap = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0)
        $display("[TB] FAIL slow_tick: actual=none required=k%0d b%0d f%0d t%0d", e.kind, e.bit_idx, e.field, e.tick);
      else begin
        o = obs_q.pop_front();
        if (o !== e)
          $display("[TB] FAIL slow_tick: actual=k%0d b%0d f%0d t%0d required=k%0d b%0d f%0d t%0d",
                   o.kind, o.bit_idx, o.field, o.tick, e.kind, e.bit_idx, e.field, e.tick);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0) $display("[TB] FAIL slow_tick_extra: actual=%0d required=0", obs_q.size());
    else passes++;
    obs_q.delete();
  endtask

  initial begin
    rst_ni = 1'b0; tick_i = 1'b0; rx_i = 1'b1; crc_en_i = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_parity_frame();
    test_crc_frame();
    test_false_start();
    test_framing_error();
    test_reset_mid_frame();
    test_slow_tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
